temp_uart_tx: RTL and testbench
===============================

Name: temp_uart_tx

Overview:
Serial transmitter that consumes the averaged temperature word produced by the accumulator stage. It captures the word on the accumulator's one-cycle ready pulse and sends a 4-byte 8N1 UART frame off-chip: header, data MSB, data LSB, checksum. The transmit pin is registered and idles high, so it can drive an output pad directly.

Parameters:
DATA_W, 8, width of the captured result word (1..16); zero-extended to 16 bits before framing.
HEADER, 8'hA5, first byte of every frame.

Ports:
clk  input  1  system clock.
reset_n  input  1  synchronous, active-low reset.
en  input  1  transmitter enable; low aborts any frame and holds the block idle.
data_in  input  DATA_W  averaged result word, valid when data_valid=1.
data_valid  input  1  one-cycle ready pulse from the accumulator.
baud_div  input  12  clocks per bit minus 1; bit period = baud_div+1 clocks.
clear_ovr  input  1  one-cycle pulse that clears overrun.
tx  output  1  UART serial out: idle 1, LSB first, 8N1.
busy  output  1  high while a frame is in progress.
overrun  output  1  sticky flag: a data_valid pulse arrived while busy.

Behaviour:
- Reset: every register is updated only on the rising edge of clk. While reset_n=0 at an edge: tx=1, busy=0, overrun=0, state=IDLE, all counters 0. Reset takes priority over every other input, including in the middle of a frame.
- States: IDLE, START, DATA, STOP. A byte index 0..3 and a bit index 0..7 run alongside the state.
- Capture (IDLE only): at an edge where en=1 and data_valid=1:
  - latch word = zero-extended data_in;
  - latch div = baud_div;
  - compute chk = HEADER ^ word[15:8] ^ word[7:0];
  - go to START with byte index 0; tx<=0 and busy<=1 take effect at that same edge.
- Sampling: baud_div changes after capture have no effect until the next capture. data_in changes after capture have no effect on the frame in progress.
- Bit timing: a bit counter loads div and counts down to 0. Each state holds tx for exactly div+1 clocks.
- Byte sequence:
  - START (tx=0) -> DATA (8 bits, LSB first) -> STOP (tx=1).
  - After STOP, if byte index < 3: increment byte index, go to START. No idle gap between bytes.
  - After STOP of byte 3: go to IDLE; busy<=0 and tx stays 1.
- Byte contents: byte0=HEADER, byte1=word[15:8], byte2=word[7:0], byte3=chk.
- Frame length: exactly 40*(div+1) clocks from the capture edge to the edge where busy falls.
- Back-to-back frames: busy is low in IDLE. A data_valid at the edge where the state is already IDLE is accepted. A data_valid at the last STOP edge, where the state is still STOP, is an overrun.
- Overrun:
  - data_valid=1 while state!=IDLE sets overrun<=1 and does not disturb the frame.
  - clear_ovr=1 clears overrun.
  - Simultaneous set and clear: set wins, overrun=1.
- en=0 at any edge: state<=IDLE, tx<=1, busy<=0, and the frame is aborted with no stop bit. overrun is held. data_valid while en=0 is ignored and does not set overrun.
- Width: chk is 8 bits and uses XOR only. DATA_W=16 uses data_in as is; DATA_W<16 zero-fills the upper bits.

Test Plan:
- DATA_W=8, baud_div=3, data_in=8'h5A pulsed once -> bytes A5,00,5A,FF on tx at 4 clk/bit; busy high for exactly 160 clocks; overrun=0.
- DATA_W=16, baud_div=0, data_in=16'h1234 -> bytes A5,12,34,83 at 1 clk/bit; busy high for 40 clocks; start bits fall right after each stop bit.
- Second data_valid 50 clocks into a baud_div=3 frame -> first frame's bytes unchanged and overrun=1. A clear_ovr pulse -> overrun=0. clear_ovr coinciding with a new busy pulse -> overrun stays 1.
- data_valid at the edge after busy falls -> new frame starts immediately, overrun=0. data_valid on the final STOP edge -> ignored, overrun=1.
- en dropped at clock 70 of a frame -> tx=1 and busy=0 at the next edge. A data_valid while en=0 -> no frame and overrun unchanged. Re-enable plus data_valid -> a full clean frame.
- reset_n low for 1 cycle mid-DATA, with overrun=1 beforehand -> tx=1, busy=0, overrun=0. baud_div changed mid-frame -> bit period of the current frame unaffected.

Source files
------------

// File: rtl/temp_uart_tx.sv
// ---------------------------------------------------------------------------
// temp_uart_tx
// Sends the averaged temperature word off-chip as a 4-byte 8N1 UART frame:
// HEADER, word[15:8], word[7:0], checksum (XOR of the first three bytes).
// The word is captured on the accumulator's one-cycle ready pulse. The tx pin
// is registered and idles high so it can drive a pad directly.
//
// Ports:
//   clk         system clock
//   reset_n     synchronous active-low reset
//   en          transmitter enable; low aborts the frame and holds idle
//   data_in     averaged result word (DATA_W bits), sampled on data_valid
//   data_valid  one-cycle ready pulse from the accumulator
//   baud_div    clocks per bit minus 1, sampled at capture
//   clear_ovr   one-cycle pulse clearing the overrun flag
//   tx          UART serial out, LSB first, idle high
//   busy        high while a frame is in progress
//   overrun     sticky: data_valid arrived while a frame was in progress
// ---------------------------------------------------------------------------
module temp_uart_tx #(
   parameter int unsigned DATA_W = 8,
   parameter logic [7:0]  HEADER = 8'hA5
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              en,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   input  logic [11:0]       baud_div,
   input  logic              clear_ovr,
   output logic              tx,
   output logic              busy,
   output logic              overrun
);

   localparam int unsigned WORD_W     = 16;
   localparam int unsigned DIV_W      = 12;
   localparam int unsigned BYTE_IDX_W = 2;
   localparam int unsigned BIT_IDX_W  = 3;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = 2'd3;
   localparam logic [BIT_IDX_W-1:0]  LAST_BIT  = 3'd7;

   // Registered state
   logic [1:0]            r_state;
   logic [WORD_W-1:0]     r_word;
   logic [7:0]            r_chk;
   logic [DIV_W-1:0]      r_div;
   logic [DIV_W-1:0]      r_cnt;
   logic [BYTE_IDX_W-1:0] r_byte_idx;
   logic [BIT_IDX_W-1:0]  r_bit_idx;
   logic                  r_tx;
   logic                  r_busy;
   logic                  r_ovr;

   // Next-state values
   logic [1:0]            w_state_nxt;
   logic [WORD_W-1:0]     w_word_nxt;
   logic [7:0]            w_chk_nxt;
   logic [DIV_W-1:0]      w_div_nxt;
   logic [DIV_W-1:0]      w_cnt_nxt;
   logic [BYTE_IDX_W-1:0] w_byte_idx_nxt;
   logic [BIT_IDX_W-1:0]  w_bit_idx_nxt;
   logic                  w_tx_nxt;
   logic                  w_busy_nxt;
   logic                  w_ovr_nxt;

   // Helpers
   logic [WORD_W-1:0]     w_word_in;
   logic [7:0]            w_cur_byte;
   logic [BIT_IDX_W-1:0]  w_bit_inc;
   logic                  w_cnt_zero;

   assign w_word_in  = WORD_W'(data_in);
   assign w_bit_inc  = r_bit_idx + 3'd1;
   assign w_cnt_zero = (r_cnt == '0);

   // Byte currently being serialised, selected by the byte index
   always_comb begin
      w_cur_byte = r_chk;
      case (r_byte_idx)
         2'd0:    w_cur_byte = HEADER;
         2'd1:    w_cur_byte = r_word[15:8];
         2'd2:    w_cur_byte = r_word[7:0];
         default: w_cur_byte = r_chk;
      endcase
   end

   // Next-state and registered-output logic
   always_comb begin
      w_state_nxt    = r_state;
      w_word_nxt     = r_word;
      w_chk_nxt      = r_chk;
      w_div_nxt      = r_div;
      w_cnt_nxt      = r_cnt;
      w_byte_idx_nxt = r_byte_idx;
      w_bit_idx_nxt  = r_bit_idx;
      w_tx_nxt       = r_tx;
      w_busy_nxt     = r_busy;
      w_ovr_nxt      = r_ovr;

      if (!en) begin
         // Abort without a stop bit; overrun is left untouched
         w_state_nxt    = ST_IDLE;
         w_tx_nxt       = 1'b1;
         w_busy_nxt     = 1'b0;
         w_cnt_nxt      = '0;
         w_byte_idx_nxt = '0;
         w_bit_idx_nxt  = '0;
      end else begin
         // Set has priority over clear
         if (data_valid && (r_state != ST_IDLE)) begin
            w_ovr_nxt = 1'b1;
         end else if (clear_ovr) begin
            w_ovr_nxt = 1'b0;
         end

         case (r_state)
            ST_IDLE: begin
               w_tx_nxt   = 1'b1;
               w_busy_nxt = 1'b0;
               if (data_valid) begin
                  w_word_nxt     = w_word_in;
                  w_div_nxt      = baud_div;
                  w_chk_nxt      = HEADER ^ w_word_in[15:8] ^ w_word_in[7:0];
                  w_cnt_nxt      = baud_div;
                  w_byte_idx_nxt = '0;
                  w_bit_idx_nxt  = '0;
                  w_tx_nxt       = 1'b0;
                  w_busy_nxt     = 1'b1;
                  w_state_nxt    = ST_START;
               end
            end

            ST_START: begin
               if (w_cnt_zero) begin
                  w_state_nxt   = ST_DATA;
                  w_bit_idx_nxt = '0;
                  w_cnt_nxt     = r_div;
                  w_tx_nxt      = w_cur_byte[0];
               end else begin
                  w_cnt_nxt = r_cnt - 12'd1;
               end
            end

            ST_DATA: begin
               if (w_cnt_zero) begin
                  w_cnt_nxt = r_div;
                  if (r_bit_idx == LAST_BIT) begin
                     w_state_nxt = ST_STOP;
                     w_tx_nxt    = 1'b1;
                  end else begin
                     w_bit_idx_nxt = w_bit_inc;
                     w_tx_nxt      = w_cur_byte[w_bit_inc];
                  end
               end else begin
                  w_cnt_nxt = r_cnt - 12'd1;
               end
            end

            ST_STOP: begin
               if (w_cnt_zero) begin
                  if (r_byte_idx == LAST_BYTE) begin
                     // Frame done; tx already high from the stop bit
                     w_state_nxt    = ST_IDLE;
                     w_busy_nxt     = 1'b0;
                     w_cnt_nxt      = '0;
                     w_byte_idx_nxt = '0;
                  end else begin
                     // Next start bit follows the stop bit with no gap
                     w_byte_idx_nxt = r_byte_idx + 2'd1;
                     w_state_nxt    = ST_START;
                     w_cnt_nxt      = r_div;
                     w_tx_nxt       = 1'b0;
                  end
               end else begin
                  w_cnt_nxt = r_cnt - 12'd1;
               end
            end

            default: begin
               w_state_nxt = ST_IDLE;
               w_tx_nxt    = 1'b1;
               w_busy_nxt  = 1'b0;
            end
         endcase
      end
   end

   // State register, synchronous reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_word     <= '0;
         r_chk      <= '0;
         r_div      <= '0;
         r_cnt      <= '0;
         r_byte_idx <= '0;
         r_bit_idx  <= '0;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
         r_ovr      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_word     <= w_word_nxt;
         r_chk      <= w_chk_nxt;
         r_div      <= w_div_nxt;
         r_cnt      <= w_cnt_nxt;
         r_byte_idx <= w_byte_idx_nxt;
         r_bit_idx  <= w_bit_idx_nxt;
         r_tx       <= w_tx_nxt;
         r_busy     <= w_busy_nxt;
         r_ovr      <= w_ovr_nxt;
      end
   end

   assign tx      = r_tx;
   assign busy    = r_busy;
   assign overrun = r_ovr;

endmodule

// File: tb/tb_temp_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_temp_uart_tx
// Directed bench for temp_uart_tx: an 8-bit instance (dut8) carries most
// scenarios, a 16-bit instance (dut16) covers the full-width word at 1 clk/bit.
// Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_temp_uart_tx;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        en;
   logic        clear_ovr;
   logic [11:0] baud_div;
   logic        dv8;
   logic        dv16;
   logic [7:0]  d8;
   logic [15:0] d16;
   logic        tx8, busy8, ovr8;
   logic        tx16, busy16, ovr16;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   temp_uart_tx #(.DATA_W(8), .HEADER(8'hA5)) dut8 (
      .clk(clk), .reset_n(reset_n), .en(en), .data_in(d8), .data_valid(dv8),
      .baud_div(baud_div), .clear_ovr(clear_ovr),
      .tx(tx8), .busy(busy8), .overrun(ovr8)
   );

   temp_uart_tx #(.DATA_W(16), .HEADER(8'hA5)) dut16 (
      .clk(clk), .reset_n(reset_n), .en(en), .data_in(d16), .data_valid(dv16),
      .baud_div(baud_div), .clear_ovr(clear_ovr),
      .tx(tx16), .busy(busy16), .overrun(ovr16)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Pulse data_valid for one edge; returns at the first sample after capture
   task automatic start_frame(input int sel, input logic [15:0] data, input logic [11:0] div);
      baud_div = div;
      if (sel != 0) begin
         d16  = data;
         dv16 = 1'b1;
      end else begin
         d8  = data[7:0];
         dv8 = 1'b1;
      end
      @(negedge clk);
      dv8  = 1'b0;
      dv16 = 1'b0;
   endtask

   // Sample every clock of a 40-bit frame, decode bytes, check bit stability
   task automatic recv_frame(input int sel, input int div, input bit late_dv,
                             output logic [31:0] bytes, output int glitch,
                             output int ferr, output int busy_cnt);
      logic       v;
      logic       bv;
      logic [7:0] cur;
      bytes = '0; glitch = 0; ferr = 0; busy_cnt = 0; bv = 1'b0; cur = '0;
      for (int byt = 0; byt < 4; byt++) begin
         for (int bitk = 0; bitk < 10; bitk++) begin
            for (int c = 0; c <= div; c++) begin
               v = (sel != 0) ? tx16 : tx8;
               if (((sel != 0) ? busy16 : busy8) === 1'b1) busy_cnt++;
               if (c == 0) bv = v;
               else if (v !== bv) glitch++;
               if (late_dv && byt == 3 && bitk == 9 && c == div) begin
                  if (sel != 0) dv16 = 1'b1; else dv8 = 1'b1;
               end
               @(negedge clk);
               dv8  = 1'b0;
               dv16 = 1'b0;
            end
            if (bitk == 0) begin
               if (bv !== 1'b0) ferr++;
            end else if (bitk == 9) begin
               if (bv !== 1'b1) ferr++;
            end else begin
               cur[bitk-1] = bv;
            end
         end
         bytes[31-8*byt -: 8] = cur;
      end
   endtask

   task automatic run_frame(input string tag, input int sel, input int div,
                            input bit late_dv, input logic [31:0] exp_bytes);
      logic [31:0] bytes;
      int glitch, ferr, busy_cnt;
      recv_frame(sel, div, late_dv, bytes, glitch, ferr, busy_cnt);
      check_val({tag, " bytes"}, bytes, exp_bytes);
      check_val({tag, " bit_glitch"}, 32'(glitch), 32'd0);
      check_val({tag, " framing"}, 32'(ferr), 32'd0);
      check_val({tag, " busy_len"}, 32'(busy_cnt), 32'(40 * (div + 1)));
      check_val({tag, " busy_end"}, 32'((sel != 0) ? busy16 : busy8), 32'd0);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int i;
      i = 0;
      while (busy8 === 1'b1 && i < budget) begin
         @(negedge clk);
         i++;
      end
      check_val({tag, " idle_timeout"}, 32'(busy8), 32'd0);
   endtask

   task automatic pulse_clear();
      clear_ovr = 1'b1;
      @(negedge clk);
      clear_ovr = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; en = 1'b1; clear_ovr = 1'b0; baud_div = '0;
      dv8 = 1'b0; dv16 = 1'b0; d8 = '0; d16 = '0;
      repeat (3) @(negedge clk);
      check_val("rst tx", 32'(tx8), 32'd1);
      check_val("rst busy", 32'(busy8), 32'd0);
      check_val("rst ovr", 32'(ovr8), 32'd0);
      check_val("rst tx16", 32'(tx16), 32'd1);
      reset_n = 1'b1;
      @(negedge clk);

      // Basic frame, 4 clk/bit
      start_frame(0, 16'h005A, 12'd3);
      run_frame("frameA", 0, 3, 1'b0, 32'hA5005AFF);
      check_val("frameA ovr", 32'(ovr8), 32'd0);

      // Back-to-back start, data_valid on the final STOP edge
      start_frame(0, 16'h003C, 12'd1);
      run_frame("b2b", 0, 1, 1'b1, 32'hA5003C99);
      check_val("late_dv ovr", 32'(ovr8), 32'd1);
      @(negedge clk);
      check_val("late_dv no_frame", 32'(busy8), 32'd0);
      pulse_clear();
      check_val("clear ovr", 32'(ovr8), 32'd0);

      // Overrun mid-frame plus baud_div/data_in change: frame unaffected
      start_frame(0, 16'h005A, 12'd3);
      fork
         run_frame("ovr_mid", 0, 3, 1'b0, 32'hA5005AFF);
         begin
            repeat (49) @(negedge clk);
            d8 = 8'h81; baud_div = 12'd0; dv8 = 1'b1;
            @(negedge clk);
            dv8 = 1'b0;
         end
      join
      check_val("ovr_mid ovr", 32'(ovr8), 32'd1);
      pulse_clear();
      check_val("ovr_mid clear", 32'(ovr8), 32'd0);

      // Simultaneous set and clear: set wins
      start_frame(0, 16'h0011, 12'd3);
      repeat (20) @(negedge clk);
      dv8 = 1'b1; clear_ovr = 1'b1;
      @(negedge clk);
      dv8 = 1'b0; clear_ovr = 1'b0;
      check_val("set_wins ovr", 32'(ovr8), 32'd1);
      wait_idle("set_wins", 400);
      pulse_clear();
      check_val("set_wins clear", 32'(ovr8), 32'd0);

      // Enable dropped at clock 70 (mid byte1, tx low)
      start_frame(0, 16'h005A, 12'd3);
      repeat (69) @(negedge clk);
      check_val("abort pre_tx", 32'(tx8), 32'd0);
      check_val("abort pre_busy", 32'(busy8), 32'd1);
      en = 1'b0;
      @(negedge clk);
      check_val("abort tx", 32'(tx8), 32'd1);
      check_val("abort busy", 32'(busy8), 32'd0);
      dv8 = 1'b1;
      @(negedge clk);
      dv8 = 1'b0;
      @(negedge clk);
      check_val("dis_dv busy", 32'(busy8), 32'd0);
      check_val("dis_dv ovr", 32'(ovr8), 32'd0);
      check_val("dis_dv tx", 32'(tx8), 32'd1);
      en = 1'b1;
      start_frame(0, 16'h00C3, 12'd2);
      run_frame("reen", 0, 2, 1'b0, 32'hA500C366);

      // Reset mid-DATA with overrun set
      start_frame(0, 16'h005A, 12'd3);
      repeat (9) @(negedge clk);
      dv8 = 1'b1;
      @(negedge clk);
      dv8 = 1'b0;
      check_val("midrst pre_ovr", 32'(ovr8), 32'd1);
      check_val("midrst pre_tx", 32'(tx8), 32'd0);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      check_val("midrst tx", 32'(tx8), 32'd1);
      check_val("midrst busy", 32'(busy8), 32'd0);
      check_val("midrst ovr", 32'(ovr8), 32'd0);
      @(negedge clk);
      check_val("midrst stay_idle", 32'(busy8), 32'd0);

      // 16-bit word at 1 clk/bit
      start_frame(1, 16'h1234, 12'd0);
      run_frame("w16", 1, 0, 1'b0, 32'hA5123483);
      check_val("w16 ovr", 32'(ovr16), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
